// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq: synchronizes GPIO pins, latches masked rise/fall edges into sticky status and drives a level irq (optional filter: GPIO_DEBOUNCE_EN)
module gpio_edge_irq #(
    parameter int BASE        = 0,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_level,
    output logic [31:0]      irq_status,
    output logic             irq
);
    localparam logic [7:0] A_RISE = 8'(BASE);
    localparam logic [7:0] A_FALL = 8'(BASE + 1);
    localparam logic [7:0] A_CLR  = 8'(BASE + 2);
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME = PW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] rise_mask_q, fall_mask_q, lvl_q, status_q, status_d;
    logic [WIDTH-1:0] lvl, clr, rise, fall;
    logic [PW-1:0]    prime_q;
    logic             irq_q, armed;

    // Metastability chain: pins land in sync_q[SYNC_STAGES-1] after SYNC_STAGES clks
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] A_DB = 8'(BASE + 3);
    logic [15:0]      db_count_q;
    logic [15:0]      cnt_q [WIDTH];
    logic [15:0]      cnt_d [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;

    // Stability filter: filtered level follows the synced pin only after db_count consecutive differing clks
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            if (db_count_q == '0) begin
                filt_d[i] = sync_q[SYNC_STAGES-1][i];
            end else if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
                if (cnt_q[i] >= db_count_q - 16'd1) filt_d[i] = sync_q[SYNC_STAGES-1][i];
                else cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // A zero count bypasses the filter register so timing matches the unfiltered build
    assign lvl = (db_count_q == '0) ? sync_q[SYNC_STAGES-1] : filt_q;

    // Debounce count register
    always_ff @(posedge clk) begin
        if (reset) db_count_q <= '0;
        else if (set_stb && set_addr == A_DB) db_count_q <= set_data[15:0];
    end
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    // Mask registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_mask_q <= '0;
            fall_mask_q <= '0;
        end else if (set_stb) begin
            if (set_addr == A_RISE) rise_mask_q <= set_data[WIDTH-1:0];
            if (set_addr == A_FALL) fall_mask_q <= set_data[WIDTH-1:0];
        end
    end

    // Edge detect against the previous level; a new edge beats a simultaneous clear
    always_comb begin
        armed    = prime_q == PRIME;
        clr      = (set_stb && set_addr == A_CLR) ? set_data[WIDTH-1:0] : '0;
        rise     = armed ? (lvl & ~lvl_q & rise_mask_q) : '0;
        fall     = armed ? (~lvl & lvl_q & fall_mask_q) : '0;
        status_d = (status_q & ~clr) | rise | fall;
    end

    // Level history, sticky status, irq and the post-reset priming counter
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q    <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            prime_q  <= '0;
        end else begin
            lvl_q    <= lvl;
            status_q <= status_d;
            irq_q    <= |status_q;
            prime_q  <= armed ? prime_q : prime_q + 1'b1;
        end
    end

    assign gpio_level = lvl_q;
    assign irq_status = 32'(status_q);
    assign irq        = irq_q;
endmodule

// File: tb/tb_gpio_edge_irq.sv
// tb_gpio_edge_irq: directed tests for gpio_edge_irq (default build, SYNC_STAGES=2, BASE=0)
module tb_gpio_edge_irq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_level;
    logic [31:0] irq_status;
    logic        irq;
    int vectors = 0;
    int miscompares = 0;

    gpio_edge_irq dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .gpio_in(gpio_in), .gpio_level(gpio_level), .irq_status(irq_status), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        tick();
        set_stb = 1'b0; set_addr = '0; set_data = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; gpio_in = 32'hFFFF_FFFF;
        tick(3);
        vectors++; if (irq_status !== 32'h0) begin miscompares++; $display("FAIL reset_status got %h exp %h", irq_status, 32'h0); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", irq); end
        vectors++; if (gpio_level !== 32'h0) begin miscompares++; $display("FAIL reset_level got %h exp %h", gpio_level, 32'h0); end
        reset = 1'b0;
        wr(8'd0, 32'hFFFF_FFFF);
        wr(8'd1, 32'hFFFF_FFFF);
        for (int i = 0; i < 20; i++) begin
            vectors++; if (irq_status !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL prime_quiet[%0d] got status %h irq %b exp 0/0", i, irq_status, irq); end
            tick();
        end
        vectors++; if (gpio_level !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL prime_level got %h exp ffffffff", gpio_level); end
    endtask

    task automatic test_rise;
        wr(8'd0, 32'h0); wr(8'd1, 32'h0);
        gpio_in = 32'h0;
        tick(4);
        wr(8'd2, 32'hFFFF_FFFF);
        wr(8'd0, 32'h1);
        tick(2);
        gpio_in = 32'h1;
        tick(2);
        vectors++; if (irq_status !== 32'h0) begin miscompares++; $display("FAIL rise_early got %h exp 0", irq_status); end
        tick();
        vectors++; if (irq_status !== 32'h1 || irq !== 1'b0) begin miscompares++; $display("FAIL rise_latch got %h irq %b exp 1/0", irq_status, irq); end
        tick();
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL rise_irq got %b exp 1", irq); end
    endtask

    task automatic test_clear_vs_set;
        gpio_in = 32'h0;
        tick(4);
        gpio_in = 32'h1;
        tick(2);
        set_stb = 1'b1; set_addr = 8'd2; set_data = 32'h1;
        tick();
        set_stb = 1'b0; set_addr = '0; set_data = '0;
        vectors++; if (irq_status !== 32'h1 || irq !== 1'b1) begin miscompares++; $display("FAIL set_wins got %h irq %b exp 1/1", irq_status, irq); end
        tick();
        vectors++; if (irq_status !== 32'h1 || irq !== 1'b1) begin miscompares++; $display("FAIL set_wins_hold got %h irq %b exp 1/1", irq_status, irq); end
        wr(8'd2, 32'h1);
        vectors++; if (irq_status !== 32'h0 || irq !== 1'b1) begin miscompares++; $display("FAIL clear0 got %h irq %b exp 0/1", irq_status, irq); end
        tick();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL clear0_irq got %b exp 0", irq); end
    endtask

    task automatic test_fall;
        wr(8'd0, 32'h0); wr(8'd1, 32'h8);
        gpio_in = 32'h9;
        tick(4);
        vectors++; if (irq_status !== 32'h0) begin miscompares++; $display("FAIL fall_on_rise got %h exp 0", irq_status); end
        gpio_in = 32'h1;
        tick(3);
        vectors++; if (irq_status !== 32'h8) begin miscompares++; $display("FAIL fall_latch got %h exp 8", irq_status); end
        gpio_in = 32'h9;
        tick(4);
        wr(8'd1, 32'h0);
        vectors++; if (irq_status !== 32'h8 || irq !== 1'b1) begin miscompares++; $display("FAIL mask_keeps got %h irq %b exp 8/1", irq_status, irq); end
        wr(8'd2, 32'h8);
        vectors++; if (irq_status !== 32'h0 || irq !== 1'b1) begin miscompares++; $display("FAIL fall_clear got %h irq %b exp 0/1", irq_status, irq); end
        tick();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL fall_irq_drop got %b exp 0", irq); end
    endtask

    task automatic test_level_track;
        logic [31:0] pats [4] = '{32'hA5A5_5A5A, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [31:0] prev;
        wr(8'd0, 32'h0); wr(8'd1, 32'h0);
        prev = gpio_in;
        for (int i = 0; i < 4; i++) begin
            gpio_in = pats[i];
            tick(2);
            vectors++; if (gpio_level !== prev) begin miscompares++; $display("FAIL level_hold[%0d] got %h exp %h", i, gpio_level, prev); end
            tick();
            vectors++; if (gpio_level !== pats[i]) begin miscompares++; $display("FAIL level_track[%0d] got %h exp %h", i, gpio_level, pats[i]); end
            vectors++; if (irq_status !== 32'h0) begin miscompares++; $display("FAIL level_nostatus[%0d] got %h exp 0", i, irq_status); end
            prev = pats[i];
        end
    endtask

    task automatic test_reset_mid;
        gpio_in = 32'h0;
        wr(8'd0, 32'h1);
        tick(4);
        gpio_in = 32'h1;
        tick(4);
        vectors++; if (irq_status !== 32'h1 || irq !== 1'b1) begin miscompares++; $display("FAIL mid_pre got %h irq %b exp 1/1", irq_status, irq); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (irq_status !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL mid_reset got %h irq %b exp 0/0", irq_status, irq); end
        gpio_in = 32'h0;
        tick(5);
        gpio_in = 32'h1;
        tick(5);
        vectors++; if (irq_status !== 32'h0) begin miscompares++; $display("FAIL mid_mask_cleared got %h exp 0", irq_status); end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce;
        gpio_in = 32'h0;
        wr(8'd3, 32'd5);
        wr(8'd0, 32'h1);
        wr(8'd2, 32'hFFFF_FFFF);
        tick(10);
        gpio_in = 32'h1;
        tick(3);
        gpio_in = 32'h0;
        tick(10);
        vectors++; if (irq_status !== 32'h0) begin miscompares++; $display("FAIL db_glitch got %h exp 0", irq_status); end
        gpio_in = 32'h1;
        tick(7);
        vectors++; if (irq_status !== 32'h0) begin miscompares++; $display("FAIL db_early got %h exp 0", irq_status); end
        tick();
        vectors++; if (irq_status !== 32'h1) begin miscompares++; $display("FAIL db_latch got %h exp 1", irq_status); end
        gpio_in = 32'h0;
        tick(12);
        vectors++; if (irq_status !== 32'h1) begin miscompares++; $display("FAIL db_single got %h exp 1", irq_status); end
    endtask
`endif

    initial begin
        test_reset();
        test_rise();
        test_clear_vs_set();
        test_fall();
        test_level_track();
        test_reset_mid();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
